// File: rtl/alu_req_arbiter_if.sv
// Bundles the client request/response lanes and the ALU issue/complete lanes of the arbiter.
// Latency: none, wires only.
// Backpressure: none in the bundle; clients hold req until granted, ALU stalls via alu_done.
// Modports: slave = arbiter view, master = the clients and ALU that surround it.
interface alu_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    // client side
    logic [NUM_REQ-1:0]        req;
    logic [3*NUM_REQ-1:0]      req_opcode;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [2*DATA_W-1:0]       rsp_data;
    logic                      rsp_err;
    logic                      busy;
    // ALU side
    logic                      alu_start;
    logic [2:0]                alu_opcode;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic                      alu_done;
    logic [2*DATA_W-1:0]       alu_result;

    modport slave (
        input  req, req_opcode, req_a, req_b, alu_done, alu_result,
        output gnt, rsp_valid, rsp_data, rsp_err, busy,
               alu_start, alu_opcode, alu_a, alu_b
    );

    modport master (
        output req, req_opcode, req_a, req_b, alu_done, alu_result,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy,
               alu_start, alu_opcode, alu_a, alu_b
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one sequential ALU among NUM_REQ requesters, with a watchdog abort.
// Latency: req sampled at edge N -> alu_start cycle N+1 -> rsp_valid earliest cycle N+3; >=4 cycles/op.
// Backpressure: requests wait in IDLE until the current op responds; ALU stalls via alu_done, bounded by TIMEOUT.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries req/opcode/operands in,
//        gnt/rsp_valid/rsp_data/rsp_err/busy out, and the alu_start/opcode/a/b -> alu_done/result handshake.
module alu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    alu_req_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state_q, state_d;

    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                alu_start_q, alu_start_d;
    logic [2:0]          opc_q, opc_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                busy_q, busy_d;

    logic                win_vld;
    logic [IDX_W-1:0]    win_idx;
    logic                wd_expired;

    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

    // Round-robin pick: first requester above the last winner, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_vld && bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            // done takes priority over the watchdog, both lead to RESP
            WAIT:    if (bus.alu_done || wd_expired) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs and datapath
    always_comb begin
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = 1'b0;
        alu_start_d = 1'b0;
        opc_d       = opc_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d       = NUM_REQ'(1) << win_idx;
                    gnt_idx_d   = win_idx;
                    opc_d       = bus.req_opcode[3*win_idx +: 3];
                    a_d         = bus.req_a[DATA_W*win_idx +: DATA_W];
                    b_d         = bus.req_b[DATA_W*win_idx +: DATA_W];
                    alu_start_d = 1'b1;
                end
            end
            ISSUE: begin
                wd_d = '0;
            end
            WAIT: begin
                if (bus.alu_done) begin
                    rsp_data_d  = bus.alu_result;
                    rsp_valid_d = gnt_q;
                end else if (wd_expired) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = gnt_q;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d = gnt_idx_q;
                gnt_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            wd_q        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            alu_start_q <= 1'b0;
            opc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            alu_start_q <= alu_start_d;
            opc_q       <= opc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_q;
    assign bus.alu_start  = alu_start_q;
    assign bus.alu_opcode = opc_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: single op, round-robin, long wait, timeout, drop/change, reset mid-op.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: the bench plays the ALU, asserting alu_done on chosen WAIT cycles.
module tb_alu_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    alu_req_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();

    alu_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_opcode[3*i +: 3] = op;
        bus.req_a[8*i +: 8]      = a;
        bus.req_b[8*i +: 8]      = b;
    endtask

    // From IDLE with req already driven: grant, issue, n_wait WAIT cycles (done on the last), respond.
    task automatic run_op(input string tag, input logic [3:0] exp_gnt, input logic [2:0] exp_op,
                          input logic [7:0] exp_a, input logic [15:0] res, input int n_wait);
        cyc();
        chk({tag, "_gnt"}, bus.gnt, exp_gnt);
        chk({tag, "_start"}, bus.alu_start, 1'b1);
        chk({tag, "_op"}, bus.alu_opcode, exp_op);
        chk({tag, "_a"}, bus.alu_a, exp_a);
        cyc();
        chk({tag, "_start_off"}, bus.alu_start, 1'b0);
        for (int i = 1; i < n_wait; i++) begin
            cyc();
            chk({tag, "_busy"}, bus.busy, 1'b1);
        end
        bus.alu_done   = 1'b1;
        bus.alu_result = res;
        cyc();
        bus.alu_done = 1'b0;
        chk({tag, "_rsp_valid"}, bus.rsp_valid, exp_gnt);
        chk({tag, "_rsp_data"}, bus.rsp_data, res);
        chk({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        chk({tag, "_gnt_resp"}, bus.gnt, exp_gnt);
        cyc();
        chk({tag, "_rsp_off"}, bus.rsp_valid, 4'b0000);
        chk({tag, "_gnt_off"}, bus.gnt, 4'b0000);
        chk({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.req        = '0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        cyc();
        cyc();
        chk("rst_gnt", bus.gnt, 4'b0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("rst_rsp_data", bus.rsp_data, 16'h0000);
        chk("rst_start", bus.alu_start, 1'b0);
        chk("rst_a", bus.alu_a, 8'h00);
        reset = 1'b0;

        // Single op, done on first WAIT cycle
        set_req(0, 3'b000, 8'h25, 8'h13);
        bus.req = 4'b0001;
        cyc();
        chk("s1_gnt", bus.gnt, 4'b0001);
        chk("s1_start", bus.alu_start, 1'b1);
        chk("s1_a", bus.alu_a, 8'h25);
        chk("s1_b", bus.alu_b, 8'h13);
        chk("s1_busy", bus.busy, 1'b1);
        bus.req = 4'b0000;
        cyc();
        chk("s1_wait_rsp", bus.rsp_valid, 4'b0000);
        bus.alu_done   = 1'b1;
        bus.alu_result = 16'h0038;
        cyc();
        bus.alu_done = 1'b0;
        chk("s1_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("s1_rsp_data", bus.rsp_data, 16'h0038);
        chk("s1_rsp_err", bus.rsp_err, 1'b0);
        cyc();
        chk("s1_rsp_off", bus.rsp_valid, 4'b0000);
        chk("s1_data_hold", bus.rsp_data, 16'h0038);

        // alu_done while IDLE is ignored
        bus.alu_done   = 1'b1;
        bus.alu_result = 16'hDEAD;
        cyc();
        bus.alu_done = 1'b0;
        cyc();
        chk("idle_done_rsp", bus.rsp_valid, 4'b0000);
        chk("idle_done_data", bus.rsp_data, 16'h0038);
        chk("idle_done_busy", bus.busy, 1'b0);

        // Round-robin from a fresh pointer: 0,1,2,3,0
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'(i), 8'(8'h11 * (i + 1)), 8'h01);
        bus.req = 4'b1111;
        run_op("rr0", 4'b0001, 3'd0, 8'h11, 16'h1000, 1);
        run_op("rr1", 4'b0010, 3'd1, 8'h22, 16'h1001, 1);
        run_op("rr2", 4'b0100, 3'd2, 8'h33, 16'h1002, 1);
        run_op("rr3", 4'b1000, 3'd3, 8'h44, 16'h1003, 1);
        run_op("rr4", 4'b0001, 3'd0, 8'h11, 16'h1004, 1);
        bus.req = 4'b0000;

        // Long multiply on requester 2
        set_req(2, 3'b010, 8'hFF, 8'hFF);
        bus.req = 4'b0100;
        run_op("mul", 4'b0100, 3'b010, 8'hFF, 16'hFE01, 10);
        bus.req = 4'b0000;

        // Timeout on requester 3: 64 WAIT cycles then error response
        set_req(3, 3'b001, 8'h05, 8'h06);
        bus.req = 4'b1000;
        cyc();
        chk("to_gnt", bus.gnt, 4'b1000);
        bus.req = 4'b0000;
        cyc();
        for (int i = 1; i < TIMEOUT; i++) cyc();
        chk("to_not_yet", bus.rsp_valid, 4'b0000);
        cyc();
        chk("to_rsp_valid", bus.rsp_valid, 4'b1000);
        chk("to_rsp_err", bus.rsp_err, 1'b1);
        chk("to_rsp_data", bus.rsp_data, 16'h0000);
        cyc();
        chk("to_err_off", bus.rsp_err, 1'b0);

        // Next request serviced normally; opcode 111 forwarded unchanged
        set_req(0, 3'b111, 8'h42, 8'h24);
        bus.req = 4'b0001;
        run_op("after_to", 4'b0001, 3'b111, 8'h42, 16'h0066, 2);
        bus.req = 4'b0000;

        // Drop/change after grant (pointer at 0, requester 1 wins)
        set_req(1, 3'b011, 8'h10, 8'h0F);
        bus.req = 4'b0010;
        cyc();
        chk("drop_gnt", bus.gnt, 4'b0010);
        chk("drop_a", bus.alu_a, 8'h10);
        bus.req = 4'b0000;
        set_req(1, 3'b100, 8'h99, 8'h77);
        cyc();
        chk("drop_a_held", bus.alu_a, 8'h10);
        chk("drop_op_held", bus.alu_opcode, 3'b011);
        bus.alu_done   = 1'b1;
        bus.alu_result = 16'h0000;
        cyc();
        bus.alu_done = 1'b0;
        chk("drop_rsp_valid", bus.rsp_valid, 4'b0010);
        cyc();

        // Reset while in WAIT, then pointer back to NUM_REQ-1
        set_req(3, 3'b101, 8'hAB, 8'hCD);
        bus.req = 4'b1000;
        cyc();
        chk("rw_gnt", bus.gnt, 4'b1000);
        bus.req = 4'b0000;
        cyc();
        chk("rw_busy", bus.busy, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rw_gnt0", bus.gnt, 4'b0000);
        chk("rw_busy0", bus.busy, 1'b0);
        chk("rw_a0", bus.alu_a, 8'h00);
        chk("rw_op0", bus.alu_opcode, 3'b000);
        chk("rw_data0", bus.rsp_data, 16'h0000);
        set_req(1, 3'b110, 8'h3C, 8'hC3);
        set_req(3, 3'b001, 8'h77, 8'h01);
        bus.req = 4'b1010;
        cyc();
        chk("rw_no_rsp", bus.rsp_valid, 4'b0000);
        chk("rw_regrant", bus.gnt, 4'b0010);
        chk("rw_regrant_a", bus.alu_a, 8'h3C);
        bus.req = 4'b0000;
        cyc();
        bus.alu_done   = 1'b1;
        bus.alu_result = 16'h00FF;
        cyc();
        bus.alu_done = 1'b0;
        chk("rw_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("rw_rsp_data", bus.rsp_data, 16'h00FF);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
